// File: rtl/lsu_pkg.sv
// ----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the MEM-stage load/store unit:
//   - operation codes carried on req_op (codes 8..15 are illegal)
//   - exception codes reported on resp_exc
//   - FSM state encoding used by mem_lsu
// ----------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [3:0] {
        LSU_LB  = 4'd0,
        LSU_LBU = 4'd1,
        LSU_LH  = 4'd2,
        LSU_LHU = 4'd3,
        LSU_LW  = 4'd4,
        LSU_SB  = 4'd5,
        LSU_SH  = 4'd6,
        LSU_SW  = 4'd7
    } lsu_op_e;

    typedef enum logic [1:0] {
        EXC_NONE   = 2'd0,
        EXC_MIS_LD = 2'd1,
        EXC_MIS_ST = 2'd2,
        EXC_ILL    = 2'd3
    } lsu_exc_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STORE  = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4,
        ST_RESP   = 3'd5
    } lsu_state_e;

endpackage

// File: rtl/lsu_lane.sv
// ----------------------------------------------------------------------------
// lsu_lane
// Purely combinational byte-lane logic for the load/store unit.
//   op        : captured operation code
//   offset    : byte offset within the word (addr[1:0])
//   word      : word read from data memory
//   wdata     : store data, right-justified (byte in [7:0], half in [15:0])
//   load_data : selected byte/half/word, sign- or zero-extended per op
//   merged    : word with the store byte/half inserted into its lane(s)
// BIG_ENDIAN=0 puts byte offset k in bits [8k+7:8k]; BIG_ENDIAN=1 puts it in
// bits [31-8k:24-8k].
// ----------------------------------------------------------------------------
module lsu_lane
    import lsu_pkg::*;
#(
    parameter int BIG_ENDIAN = 0
) (
    input  logic [3:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    // Physical lane (0 = bits [7:0]) holding the addressed byte, and the
    // lower physical lane of the addressed halfword (0 or 2). In big-endian
    // mode the byte at the lower address is the more significant one, so a
    // halfword at offset 0 occupies physical lanes 3:2.
    logic [1:0]  lane_b;
    logic [1:0]  lane_h;
    logic [1:0]  lane;
    logic        is_half;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [3:0]  lane_en;
    logic [31:0] ins_data;
    logic        unused_wdata;

    assign unused_wdata = ^wdata[31:16];

    always_comb begin
        lane_b = (BIG_ENDIAN != 0) ? ~offset : offset;
        lane_h = (BIG_ENDIAN != 0) ? {~offset[1], 1'b0} : {offset[1], 1'b0};

        case (lane_b)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = lane_h[1] ? word[31:16] : word[15:0];

        case (op)
            LSU_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
            LSU_LBU: load_data = {24'h0, byte_sel};
            LSU_LH:  load_data = {{16{half_sel[15]}}, half_sel};
            LSU_LHU: load_data = {16'h0, half_sel};
            default: load_data = word;
        endcase

        is_half  = (op == LSU_SH);
        lane     = is_half ? lane_h : lane_b;
        lane_en  = is_half ? (4'b0011 << lane) : (4'b0001 << lane);
        ins_data = (is_half ? {16'h0, wdata[15:0]} : {24'h0, wdata[7:0]})
                   << {lane, 3'b000};
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign merged[8*gi +: 8] = lane_en[gi] ? ins_data[8*gi +: 8]
                                                   : word[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/mem_lsu.sv
// ----------------------------------------------------------------------------
// mem_lsu
// Load/store initiator for the MEM stage. Converts one CPU memory op into
// accesses on a word-only data-memory port; sub-word stores are done as a
// read-modify-write.
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/ready   : request handshake (ready only in IDLE)
//   req_op/addr/wdata : operation, byte address, right-justified store data
//   stall_req         : pipeline stall while an access is in flight
//   resp_valid        : one-cycle completion pulse
//   resp_rdata        : extended load data (0 for stores and errors)
//   resp_exc          : exception code (lsu_exc_e)
//   mem_addr          : word-aligned memory address
//   mem_read_en       : memory read strobe
//   mem_write_en      : memory write strobe (never asserted while rst is high)
//   mem_write_data    : full word to write
//   mem_result        : combinational read data from memory
// ----------------------------------------------------------------------------
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int BIG_ENDIAN = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall_req,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic [1:0]        resp_exc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_result
);

    lsu_state_e        state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    // Holds the store data, then the merged word once an RMW read completes.
    logic [31:0]       data_q, data_d;
    logic [31:0]       rdata_q, rdata_d;
    lsu_exc_e          exc_q, exc_d;

    logic [31:0]       load_data;
    logic [31:0]       merged;
    logic              req_misaligned;
    logic              req_is_store;

    lsu_lane #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_lane (
        .op        (op_q),
        .offset    (addr_q[1:0]),
        .word      (mem_result),
        .wdata     (data_q),
        .load_data (load_data),
        .merged    (merged)
    );

    always_comb begin
        req_is_store   = (req_op == LSU_SB) || (req_op == LSU_SH) ||
                         (req_op == LSU_SW);
        req_misaligned = (((req_op == LSU_LH) || (req_op == LSU_LHU) ||
                           (req_op == LSU_SH)) && req_addr[0]) ||
                         (((req_op == LSU_LW) || (req_op == LSU_SW)) &&
                          (req_addr[1:0] != 2'b00));
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        exc_d   = exc_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    data_d  = req_wdata;
                    rdata_d = '0;
                    exc_d   = EXC_NONE;
                    if (req_op[3]) begin
                        exc_d   = EXC_ILL;
                        state_d = ST_RESP;
                    end else if (req_misaligned) begin
                        exc_d   = req_is_store ? EXC_MIS_ST : EXC_MIS_LD;
                        state_d = ST_RESP;
                    end else if (req_op == LSU_SW) begin
                        state_d = ST_STORE;
                    end else if (req_is_store) begin
                        state_d = ST_RMW_RD;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                rdata_d = load_data;
                state_d = ST_RESP;
            end
            ST_STORE: begin
                state_d = ST_RESP;
            end
            ST_RMW_RD: begin
                data_d  = merged;
                state_d = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            exc_q   <= EXC_NONE;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            exc_q   <= exc_d;
        end
    end

    // Memory-side outputs decode from state and captured registers only.
    logic access_rd;
    logic access_wr;

    always_comb begin
        access_rd      = (state_q == ST_LOAD) || (state_q == ST_RMW_RD);
        access_wr      = (state_q == ST_STORE) || (state_q == ST_RMW_WR);
        mem_read_en    = access_rd;
        mem_write_en   = access_wr && !rst;
        mem_addr       = (access_rd || access_wr) ? {addr_q[ADDR_W-1:2], 2'b00}
                                                  : '0;
        mem_write_data = access_wr ? data_q : '0;
        req_ready      = (state_q == ST_IDLE);
        stall_req      = (state_q != ST_IDLE) && (state_q != ST_RESP);
        resp_valid     = (state_q == ST_RESP);
        resp_rdata     = rdata_q;
        resp_exc       = exc_q;
    end

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = 4'h0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        stall_req;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_exc;
    logic [31:0] mem_addr;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] mem_write_data;
    logic [31:0] mem_result;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_lsu #(.ADDR_W(32), .BIG_ENDIAN(0)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .stall_req      (stall_req),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_exc       (resp_exc),
        .mem_addr       (mem_addr),
        .mem_read_en    (mem_read_en),
        .mem_write_en   (mem_write_en),
        .mem_write_data (mem_write_data),
        .mem_result     (mem_result)
    );

    // Simple word memory with combinational read.
    logic [31:0] mem [0:255];
    assign mem_result = mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_write_en) mem[mem_addr[9:2]] <= mem_write_data;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic [1:0] exc,
                          output int lat, output int nrd, output int nwr, output int wr_cyc,
                          output logic proto_ok);
        int k;
        lat = 0; nrd = 0; nwr = 0; wr_cyc = 0; proto_ok = 1'b1;
        rdata = '0; exc = '0;
        k = 0;
        while (!req_ready && k < 10) begin
            @(negedge clk);
            k++;
        end
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        // Scramble inputs to prove the request was captured.
        req_valid = 1'b0; req_op = 4'h0; req_addr = '1; req_wdata = '1;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            if (mem_read_en) nrd++;
            if (mem_write_en) begin nwr++; wr_cyc = c; end
            if ((mem_read_en || mem_write_en) && mem_addr !== {addr[31:2], 2'b00}) proto_ok = 1'b0;
            if (resp_valid) begin
                lat = c; rdata = resp_rdata; exc = resp_exc;
                if (stall_req || req_ready) proto_ok = 1'b0;
            end else if (!stall_req || req_ready) begin
                proto_ok = 1'b0;
            end
        end
        @(negedge clk);
        if (resp_valid || !req_ready) proto_ok = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_exc;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    logic [31:0] g_rdata;
    logic [1:0]  g_exc;
    int          g_lat, g_rd, g_wr, g_wc;
    logic        g_ok;
    logic [2:0]  smp [5];
    logic [2:0]  exp_smp [5];
    logic        saw_valid;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10 >> 2] = 32'h80FF7F01;
        mem[8'h30 >> 2] = 32'h11223344;

        //          op       addr   wdata         rdata         exc lat rd wr
        vecs[0]  = '{LSU_LB,  32'h13, 32'h0,        32'hFFFFFF80, 2'd0, 2, 1, 0};
        vecs[1]  = '{LSU_LBU, 32'h13, 32'h0,        32'h00000080, 2'd0, 2, 1, 0};
        vecs[2]  = '{LSU_LH,  32'h12, 32'h0,        32'hFFFF80FF, 2'd0, 2, 1, 0};
        vecs[3]  = '{LSU_LHU, 32'h10, 32'h0,        32'h00007F01, 2'd0, 2, 1, 0};
        vecs[4]  = '{LSU_LW,  32'h10, 32'h0,        32'h80FF7F01, 2'd0, 2, 1, 0};
        vecs[5]  = '{LSU_SW,  32'h20, 32'hDEADBEEF, 32'h0,        2'd0, 2, 0, 1};
        vecs[6]  = '{LSU_LW,  32'h20, 32'h0,        32'hDEADBEEF, 2'd0, 2, 1, 0};
        vecs[7]  = '{LSU_SB,  32'h31, 32'h000000AA, 32'h0,        2'd0, 3, 1, 1};
        vecs[8]  = '{LSU_LW,  32'h30, 32'h0,        32'h1122AA44, 2'd0, 2, 1, 0};
        vecs[9]  = '{LSU_SH,  32'h32, 32'h0000BBCC, 32'h0,        2'd0, 3, 1, 1};
        vecs[10] = '{LSU_LW,  32'h30, 32'h0,        32'hBBCCAA44, 2'd0, 2, 1, 0};
        vecs[11] = '{LSU_LW,  32'h22, 32'h0,        32'h0,        2'd1, 1, 0, 0};
        vecs[12] = '{LSU_SH,  32'h33, 32'h1234,     32'h0,        2'd2, 1, 0, 0};
        vecs[13] = '{4'd9,    32'h10, 32'h0,        32'h0,        2'd3, 1, 0, 0};
        vecs[14] = '{LSU_LH,  32'h11, 32'h0,        32'h0,        2'd1, 1, 0, 0};
        vecs[15] = '{LSU_SB,  32'h13, 32'hFFFFFF55, 32'h0,        2'd0, 3, 1, 1};
        vecs[16] = '{LSU_LHU, 32'h12, 32'h0,        32'h000055FF, 2'd0, 2, 1, 0};
        vecs[17] = '{4'd15,   32'h0,  32'h0,        32'h0,        2'd3, 1, 0, 0};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_exc", {30'h0, resp_exc}, 32'h0);
        check("rst_stall", {31'h0, stall_req}, 32'h0);
        check("rst_ready", {31'h0, req_ready}, 32'h1);
        check("rst_mem_ctl", {30'h0, mem_read_en, mem_write_en}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_write_data, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven vectors
        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].op, vecs[i].addr, vecs[i].wdata, g_rdata, g_exc, g_lat, g_rd, g_wr, g_wc, g_ok);
            $display("[TB] vec %0d op=%0d addr=%h wdata=%h -> rdata=%h exc=%0d lat=%0d rd=%0d wr=%0d",
                     i, vecs[i].op, vecs[i].addr, vecs[i].wdata, g_rdata, g_exc, g_lat, g_rd, g_wr);
            check($sformatf("v%0d_rdata", i), g_rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d_exc", i), {30'h0, g_exc}, {30'h0, vecs[i].exp_exc});
            check($sformatf("v%0d_lat", i), 32'(g_lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_nrd", i), 32'(g_rd), 32'(vecs[i].exp_rd));
            check($sformatf("v%0d_nwr", i), 32'(g_wr), 32'(vecs[i].exp_wr));
            check($sformatf("v%0d_proto", i), {31'h0, g_ok}, 32'h1);
            if (vecs[i].exp_wr != 0)
                check($sformatf("v%0d_wrcyc", i), 32'(g_wc), 32'(vecs[i].exp_lat - 1));
        end

        // Back-to-back lw with req_valid held: {ready, stall, valid} per cycle
        exp_smp[0] = 3'b010; exp_smp[1] = 3'b001; exp_smp[2] = 3'b100;
        exp_smp[3] = 3'b010; exp_smp[4] = 3'b001;
        req_valid = 1'b1; req_op = LSU_LW; req_addr = 32'h10; req_wdata = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            smp[c] = {req_ready, stall_req, resp_valid};
        end
        req_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            $display("[TB] b2b cycle %0d ready/stall/valid=%b", c + 1, smp[c]);
            check($sformatf("b2b_c%0d", c + 1), {29'h0, smp[c]}, {29'h0, exp_smp[c]});
        end
        @(negedge clk);
        @(negedge clk);

        // sb aborted by reset during RMW_WR
        req_valid = 1'b1; req_op = LSU_SB; req_addr = 32'h30; req_wdata = 32'h77;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("abort_rmw_rd", {31'h0, mem_read_en}, 32'h1);
        @(negedge clk);
        check("abort_rmw_wr_pre", {31'h0, mem_write_en}, 32'h1);
        rst = 1'b1;
        #1;
        check("abort_wr_gated", {31'h0, mem_write_en}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        $display("[TB] abort after reset: valid=%b rdata=%h exc=%0d stall=%b ready=%b rd=%b wr=%b addr=%h wd=%h",
                 resp_valid, resp_rdata, resp_exc, stall_req, req_ready, mem_read_en, mem_write_en, mem_addr, mem_write_data);
        check("abort_resp", {resp_valid, resp_exc, stall_req, mem_read_en, mem_write_en}, 32'h0);
        check("abort_rdata", resp_rdata, 32'h0);
        check("abort_ready", {31'h0, req_ready}, 32'h1);
        check("abort_mem_addr", mem_addr, 32'h0);
        check("abort_mem_wdata", mem_write_data, 32'h0);
        saw_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) saw_valid = 1'b1;
        end
        check("abort_no_resp", {31'h0, saw_valid}, 32'h0);
        run_op(LSU_LW, 32'h30, 32'h0, g_rdata, g_exc, g_lat, g_rd, g_wr, g_wc, g_ok);
        $display("[TB] post-abort lw 0x30 -> rdata=%h lat=%0d", g_rdata, g_lat);
        check("abort_word_kept", g_rdata, 32'hBBCCAA44);
        check("abort_lw_lat", 32'(g_lat), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
Load/store initiator for the MEM pipeline stage. It turns one CPU memory operation (lb/lbu/lh/lhu/lw/sb/sh/sw) into accesses on the word-only data-memory port: mem_addr, mem_read_en, mem_write_en, mem_write_data and mem_result, where mem_result is a combinational read. Sub-word stores use a read-modify-write sequence. The block also extracts and extends sub-word load data, detects misalignment and illegal ops, and tells the pipeline when it is busy.

Parameters:
ADDR_W, 32, byte-address width; the memory port is word-addressed through mem_addr[ADDR_W-1:2].
BIG_ENDIAN, 0, byte-lane mapping. 0: byte offset k maps to bits [8k+7:8k]. 1: byte offset k maps to bits [31-8k:24-8k].

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  1  request presented by the pipeline
req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready
req_op  in  4  operation code, encoded per the package
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-justified for sb/sh
stall_req  out  1  pipeline stall, high in every state except IDLE and RESP
resp_valid  out  1  one-cycle pulse when the operation completes
resp_rdata  out  32  load result, extended; 0 for stores and errors
resp_exc  out  2  0 none, 1 misaligned load, 2 misaligned store, 3 illegal op
mem_addr  out  ADDR_W  word-aligned address, bits [1:0] always 0
mem_read_en  out  1  read strobe to data memory
mem_write_en  out  1  write strobe to data memory
mem_write_data  out  32  full word to write
mem_result  in  32  combinational read data from memory

Behaviour:
- Reset: clk and rst only; synchronous, active-high.
  - On the next edge: state = IDLE; resp_valid=0, resp_rdata=0, resp_exc=0, stall_req=0.
  - mem_read_en=0, mem_write_en=0, mem_addr=0, mem_write_data=0.
  - req_ready=1 after reset.
- Request capture: on acceptance, op, addr and wdata are registered. The requester need not hold them afterwards.
- Output timing: all memory-side outputs come from state and the captured registers only; there is no combinational path from req_* to mem_*. Outside the access states listed below, the mem outputs are 0.
- Write safety: mem_write_en is gated by !rst, so no write happens in any cycle where rst is high.
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- IDLE, on accept:
  - Illegal op (codes 8..15) -> RESP with exc=3.
  - lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=0 -> RESP with exc=1 (load) or 2 (store). No memory access occurs.
  - Otherwise: loads -> LOAD, sw -> STORE, sb/sh -> RMW_RD.
- LOAD: mem_read_en=1, mem_addr = addr with bits [1:0] cleared.
  - Lane select uses addr[1:0] (byte) or addr[1] (half).
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the whole word.
  - The result is registered into resp_rdata. -> RESP.
- STORE: mem_write_en=1, mem_write_data = wdata. -> RESP.
- RMW_RD: mem_read_en=1. The word is latched with the new byte or half merged into the addressed lane; other lanes are unchanged. -> RMW_WR.
- RMW_WR: mem_write_en=1, mem_write_data = merged word. -> RESP.
- RESP: resp_valid=1 for exactly one cycle with resp_rdata/resp_exc stable. -> IDLE. req_ready=0 in RESP, so back-to-back requests are separated by one IDLE cycle.
- Latency (accept edge T, response cycle):
  - load: T+2
  - sw: T+2
  - sb/sh: T+3
  - error: T+1
- Reset mid-operation: the operation is abandoned with no response. An RMW aborted in RMW_RD, or in RMW_WR with rst high, performs no write.
- req_valid while not IDLE: ignored; it is not queued.

Decomposition:
- Package lsu_pkg holds:
  - op codes LSU_LB=0, LSU_LBU=1, LSU_LH=2, LSU_LHU=3, LSU_LW=4, LSU_SB=5, LSU_SH=6, LSU_SW=7;
  - exception codes EXC_NONE/EXC_MIS_LD/EXC_MIS_ST/EXC_ILL;
  - the state encoding.
- One combinational sub-module, lsu_lane. It performs lane extract/extend for loads and lane merge for stores, honouring BIG_ENDIAN.

Test Plan:
- Memory preset 0x80FF7F01 at 0x10, BIG_ENDIAN=0:
  - lb 0x13 -> resp_rdata 0xFFFFFF80 at T+2;
  - lbu 0x13 -> 0x00000080;
  - lh 0x12 -> 0xFFFF80FF;
  - lhu 0x10 -> 0x00007F01.
- sw 0x20 data 0xDEADBEEF -> single mem_write_en cycle at T+1 with mem_addr 0x20; a following lw 0x20 returns 0xDEADBEEF.
- Word 0x11223344 at 0x30:
  - sb 0x31 data 0x000000AA -> read at T+1, write 0x1122AA44 at T+2, resp at T+3;
  - then sh 0x32 data 0xBBCC -> 0xBBCCAA44.
- lw 0x22 -> resp_exc=1 at T+1; sh 0x33 -> resp_exc=2. mem_read_en and mem_write_en stay 0 throughout.
- req_op=9 -> resp_exc=3, resp_rdata=0. Check stall_req and req_ready across two back-to-back lw requests.
- sb in progress with rst asserted during the RMW_WR cycle -> no write to memory (word unchanged), no resp_valid, all outputs 0 after the edge, req_ready=1.
